// File: rtl/tl_pkg.sv
// ----------------------------------------------------------------------------
// tl_pkg
// Shared types and default parameter values for the traffic-light front end.
//   db_state_t        : debounce FSM state encoding
//   *_DEF localparams : default synchroniser depth, debounce time, phase length
// ----------------------------------------------------------------------------
package tl_pkg;

   typedef enum logic [1:0] {
      DB_REL,        // released and stable
      DB_PRE_PRESS,  // synced input went high, waiting for it to hold
      DB_PRESS,      // pressed and stable
      DB_PRE_REL     // synced input went low, waiting for it to hold
   } db_state_t;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned TICK_CYCLES_DEF     = 50_000_000;

endpackage

// File: rtl/tl_input_timer_if.sv
// ----------------------------------------------------------------------------
// tl_input_timer_if
// Signal bundle between the input/timer front end and the controller.
//   btn_raw    : raw button level into the front end
//   cntr_reset : synchronous timer restart from the controller
//   btn        : one-cycle pulse per debounced press
//   tick       : one-cycle pulse at the end of each interval
//   pressed    : debounced button level
// slave  = front-end side, master = controller / stimulus side.
// ----------------------------------------------------------------------------
interface tl_input_timer_if;

   logic btn_raw;
   logic cntr_reset;
   logic btn;
   logic tick;
   logic pressed;

   modport slave (
      input  btn_raw,
      input  cntr_reset,
      output btn,
      output tick,
      output pressed
   );

   modport master (
      output btn_raw,
      output cntr_reset,
      input  btn,
      input  tick,
      input  pressed
   );

endinterface

// File: rtl/tl_debounce.sv
// ----------------------------------------------------------------------------
// tl_debounce
// Synchronises an asynchronous button level and debounces it.
//   clk        in  : clock, all logic on posedge
//   res        in  : asynchronous active-high reset
//   din        in  : raw asynchronous level
//   level      out : debounced level, registered
//   rise_pulse out : one-cycle pulse when a press is accepted, registered
// A new level is accepted only once the synchronised input has held it long
// enough; any return to the old level during the wait restarts the decision.
// ----------------------------------------------------------------------------
module tl_debounce
   import tl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic res,
   input  logic din,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   db_state_t     r_state, w_state_nxt;
   logic [CW-1:0] r_cnt,   w_cnt_nxt;
   logic          r_level, w_level_nxt;
   logic          r_pulse, w_pulse_nxt;

   // Synchroniser chain; din enters at bit 0, the debouncer reads the far end.
   always_ff @(posedge clk or posedge res) begin
      if (res) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], din};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state <= DB_REL;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_pulse_nxt = 1'b0;
      case (r_state)
         DB_REL: begin
            if (w_s) begin
               w_state_nxt = DB_PRE_PRESS;
               w_cnt_nxt   = '0;
            end
         end
         DB_PRE_PRESS: begin
            // A bounce back to 0 beats the terminal count.
            if (!w_s) begin
               w_state_nxt = DB_REL;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = DB_PRESS;
               w_level_nxt = 1'b1;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         DB_PRESS: begin
            if (!w_s) begin
               w_state_nxt = DB_PRE_REL;
               w_cnt_nxt   = '0;
            end
         end
         DB_PRE_REL: begin
            // Release is silent: the level drops but no pulse is produced.
            if (w_s) begin
               w_state_nxt = DB_PRESS;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = DB_REL;
               w_level_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = DB_REL;
         end
      endcase
   end

   assign level      = r_level;
   assign rise_pulse = r_pulse;

endmodule

// File: rtl/tl_input_timer.sv
// ----------------------------------------------------------------------------
// tl_input_timer
// Front end of the traffic-light controller: debounced pedestrian button and
// the free-running phase tick.
//   clk  in : clock, all logic on posedge
//   res  in : asynchronous active-high reset
//   bus     : tl_input_timer_if.slave
//             btn_raw/cntr_reset in, btn/tick/pressed out (all registered)
// The button path and the timer are independent; btn and tick may pulse in
// the same cycle and the controller decides priority.
// ----------------------------------------------------------------------------
module tl_input_timer
   import tl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            res,
   tl_input_timer_if.slave bus
);

   localparam int unsigned TW = $clog2(TICK_CYCLES);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_CYCLES - 1);

   logic          w_level;
   logic          w_rise;
   logic [TW-1:0] r_tcnt;
   logic          r_tick;

   tl_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .res        (res),
      .din        (bus.btn_raw),
      .level      (w_level),
      .rise_pulse (w_rise)
   );

   // Interval timer. The restart has priority over the terminal count, so a
   // restart landing on the last count swallows that tick.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_tcnt <= '0;
         r_tick <= 1'b0;
      end else if (bus.cntr_reset) begin
         r_tcnt <= '0;
         r_tick <= 1'b0;
      end else if (r_tcnt == TCNT_LAST) begin
         r_tcnt <= '0;
         r_tick <= 1'b1;
      end else begin
         r_tcnt <= r_tcnt + TW'(1);
         r_tick <= 1'b0;
      end
   end

   assign bus.btn     = w_rise;
   assign bus.pressed = w_level;
   assign bus.tick    = r_tick;

endmodule

// File: tb/tb_tl_input_timer.sv
module tb_tl_input_timer;
   localparam int SS = 2;
   localparam int DB = 4;
   localparam int TC = 5;

   logic clk = 1'b0;
   logic res = 1'b1;
   int   checks = 0;
   int   errors = 0;

   tl_input_timer_if bus();

   tl_input_timer #(
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DB),
      .TICK_CYCLES     (TC)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: the synced level is the raw input seen SS edges ago;
   // the debounced level flips once the last DB+1 synced samples all
   // disagree with it; a tick fires whenever the number of edges since the
   // last restart is a non-zero multiple of TC.
   bit raw_q[$];
   bit s_q[$];
   bit m_lvl, m_btn, m_tick;
   int m_since;

   typedef struct {
      logic raw;
      logic cr;
      logic btn;
      logic tick;
      logic pressed;
   } vec_t;
   vec_t vt[16];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      raw_q.delete();
      s_q.delete();
      m_lvl   = 1'b0;
      m_btn   = 1'b0;
      m_tick  = 1'b0;
      m_since = 0;
   endfunction

   function automatic void m_edge(input bit raw, input bit cr);
      bit s;
      bit all_opp;
      raw_q.push_back(raw);
      s = (raw_q.size() > SS) ? raw_q[raw_q.size()-1-SS] : 1'b0;
      s_q.push_back(s);
      all_opp = (s_q.size() >= DB + 1);
      for (int k = 0; k < DB + 1 && all_opp; k++)
         if (s_q[s_q.size()-1-k] == m_lvl) all_opp = 1'b0;
      m_btn = 1'b0;
      if (all_opp) begin
         m_lvl = !m_lvl;
         m_btn = m_lvl;
      end
      if (cr) begin
         m_since = 0;
         m_tick  = 1'b0;
      end else begin
         m_since++;
         m_tick = ((m_since % TC) == 0);
      end
   endfunction

   // One clock: drive inputs, take the edge, then compare against the model.
   task automatic step(input logic raw, input logic cr);
      bus.btn_raw    = raw;
      bus.cntr_reset = cr;
      @(posedge clk);
      #1;
      m_edge(raw, cr);
      chk("m_btn", bus.btn, m_btn);
      chk("m_tick", bus.tick, m_tick);
      chk("m_pressed", bus.pressed, m_lvl);
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic do_reset();
      @(posedge clk);
      #3;
      res = 1'b1;
      #1;
      chk("rst_btn", bus.btn, 1'b0);
      chk("rst_tick", bus.tick, 1'b0);
      chk("rst_pressed", bus.pressed, 1'b0);
      bus.btn_raw    = 1'b0;
      bus.cntr_reset = 1'b0;
      @(posedge clk);
      #2;
      res = 1'b0;
      m_reset();
   endtask

   initial begin
      bit cur;
      bus.btn_raw    = 1'b0;
      bus.cntr_reset = 1'b0;

      // Button held from edge 1: tick at 5/10/15, single press pulse at 7.
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      #12;
      chk("init_btn", bus.btn, 1'b0);
      chk("init_tick", bus.tick, 1'b0);
      chk("init_pressed", bus.pressed, 1'b0);
      do_reset();

      foreach (vt[i]) begin
         step(vt[i].raw, vt[i].cr);
         chk("tbl_btn", bus.btn, vt[i].btn);
         chk("tbl_tick", bus.tick, vt[i].tick);
         chk("tbl_pressed", bus.pressed, vt[i].pressed);
      end
      for (int c = 17; c <= 20; c++) step(1'b1, 1'b0);

      // Reset while pressed, then first tick 5 clocks after release.
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         step(1'b0, 1'b0);
         chk("t1_tick", bus.tick, c == 5);
      end

      // Restart at count 3: no tick at 5, next one 5 clocks after the restart.
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         step(1'b0, c == 4);
         chk("t3_tick", bus.tick, c == 9);
      end

      // Restart on the terminal count swallows that tick.
      do_reset();
      for (int c = 1; c <= 11; c++) begin
         step(1'b0, c == 5);
         chk("t4_tick", bus.tick, c == 10);
      end

      // 3-clock glitch is rejected.
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         step(c <= 3, 1'b0);
         chk("t5_btn", bus.btn, 1'b0);
         chk("t5_pressed", bus.pressed, 1'b0);
      end

      // Release with a bounce: level falls 6 edges after the steady 0 starts.
      do_reset();
      for (int c = 1; c <= 12; c++) step(1'b1, 1'b0);
      chk("t6_held", bus.pressed, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int d = 0; d < 12; d++) begin
         step(1'b0, 1'b0);
         chk("t6_btn", bus.btn, 1'b0);
         chk("t6_pressed", bus.pressed, d < 6);
      end

      // Press accepted in the same cycle as a tick.
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         step(c >= 4, 1'b0);
         chk("t7_btn", bus.btn, c == 10);
         if (c == 10) chk("t7_tick", bus.tick, 1'b1);
      end

      // Random bouncy button and sporadic restarts against the model.
      do_reset();
      cur = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) cur = !cur;
         step(cur, $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
